// File: rtl/phase_timer_pkg.sv
// Shared definitions for the phase timer: state encoding and default sizing.
package phase_timer_pkg;

   localparam int CLK_HZ_DEF = 10000;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      LOAD = 2'd2,
      RUN  = 2'd3
   } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle sec_tick every CLK_HZ counting cycles.
module tick_prescaler
   import phase_timer_pkg::*;
#(
   parameter int CLK_HZ = CLK_HZ_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic sec_tick
);

   localparam int               PRE_W = $clog2(CLK_HZ);
   localparam logic [PRE_W-1:0] LAST  = PRE_W'(CLK_HZ - 1);

   logic [PRE_W-1:0] r_count;
   logic             w_wrap;

   assign w_wrap = (r_count == LAST);

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (run) begin
         r_count <= w_wrap ? '0 : r_count + 1'b1;
      end
   end

   assign sec_tick = run && w_wrap;

endmodule

// File: rtl/phase_timer.sv
// Seconds-based phase timer: pulses finished, samples the next duration, counts it down.
// Optional pause input is enabled by defining PHASE_TIMER_PAUSE_EN.
module phase_timer
   import phase_timer_pkg::*;
#(
   parameter int CLK_HZ = CLK_HZ_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [CNT_W-1:0] seconds_to_count,
   output logic             finished,
   output logic             busy,
   output logic [CNT_W-1:0] remaining_s
`ifdef PHASE_TIMER_PAUSE_EN
   ,
   input  logic             pause
`endif
);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [CNT_W-1:0] r_remaining;
   logic [CNT_W-1:0] w_remaining_nxt;
   logic             r_finished;
   logic             r_busy;
   logic             w_sec_tick;
   logic             w_pre_clear;
   logic             w_pre_run;

   // The prescaler only advances in RUN; any other state (or enable low) holds it at zero.
   assign w_pre_clear = !enable || (r_state != RUN);
`ifdef PHASE_TIMER_PAUSE_EN
   assign w_pre_run   = enable && (r_state == RUN) && !pause;
`else
   assign w_pre_run   = enable && (r_state == RUN);
`endif

   tick_prescaler #(
      .CLK_HZ(CLK_HZ)
   ) u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .clear   (w_pre_clear),
      .run     (w_pre_run),
      .sec_tick(w_sec_tick)
   );

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt     = r_state;
      w_remaining_nxt = r_remaining;
      if (!enable) begin
         w_state_nxt     = IDLE;
         w_remaining_nxt = '0;
      end else begin
         case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ:  w_state_nxt = LOAD;
            LOAD: begin
               w_remaining_nxt = (seconds_to_count == '0) ? CNT_W'(1) : seconds_to_count;
               w_state_nxt     = RUN;
            end
            RUN: begin
               if (w_sec_tick) begin
                  if (r_remaining == CNT_W'(1)) begin
                     w_remaining_nxt = '0;
                     w_state_nxt     = REQ;
                  end else begin
                     w_remaining_nxt = r_remaining - 1'b1;
                  end
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Outputs decode the next state so they are registered yet aligned with the state they describe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_remaining <= '0;
         r_finished  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_remaining <= w_remaining_nxt;
         r_finished  <= (w_state_nxt == REQ);
         r_busy      <= (w_state_nxt == LOAD) || (w_state_nxt == RUN);
      end
   end

   assign finished    = r_finished;
   assign busy        = r_busy;
   assign remaining_s = r_remaining;

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer at CLK_HZ=10; pause scenario built when PHASE_TIMER_PAUSE_EN is defined.
module tb_phase_timer;

   localparam int CLK_HZ = 10;
   localparam int CNT_W  = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic [CNT_W-1:0] seconds_to_count;
   logic             finished;
   logic             busy;
   logic [CNT_W-1:0] remaining_s;
`ifdef PHASE_TIMER_PAUSE_EN
   logic             pause;
`endif

   int vectors     = 0;
   int miscompares = 0;

   phase_timer #(
      .CLK_HZ(CLK_HZ),
      .CNT_W (CNT_W)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .seconds_to_count(seconds_to_count),
      .finished        (finished),
      .busy            (busy),
      .remaining_s     (remaining_s)
`ifdef PHASE_TIMER_PAUSE_EN
      ,
      .pause           (pause)
`endif
   );

   always #5 clk = ~clk;

   // Advance n rising edges, landing 1 time unit after the last one.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Cycles until finished is seen high, or -1 if the budget runs out.
   task automatic wait_pulse(input int max_cycles, output int n);
      n = -1;
      for (int i = 1; i <= max_cycles; i++) begin
         tick(1);
         if (finished === 1'b1) begin
            n = i;
            return;
         end
      end
   endtask

   task automatic test_reset();
      reset            = 1'b0;
      enable           = 1'b1;
      seconds_to_count = 16'd3;
`ifdef PHASE_TIMER_PAUSE_EN
      pause            = 1'b0;
`endif
      tick(2);
      vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL reset_finished: got %b want 0", finished); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (remaining_s !== 16'd0) begin miscompares++; $display("FAIL reset_remaining: got %0d want 0", remaining_s); end
   endtask

   task automatic test_first_phase();
      int n;
      reset = 1'b1;
      vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL first_pre_edge: finished=%b want 0", finished); end
      tick(1);
      vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL first_pulse: finished=%b want 1", finished); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL first_req_busy: busy=%b want 0", busy); end
      tick(1);
      vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL first_pulse_width: finished=%b want 0", finished); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL first_load_busy: busy=%b want 1", busy); end
      tick(1);
      vectors++; if (remaining_s !== 16'd3) begin miscompares++; $display("FAIL first_rem3: got %0d want 3", remaining_s); end
      tick(10);
      vectors++; if (remaining_s !== 16'd2) begin miscompares++; $display("FAIL first_rem2: got %0d want 2", remaining_s); end
      tick(10);
      vectors++; if (remaining_s !== 16'd1) begin miscompares++; $display("FAIL first_rem1: got %0d want 1", remaining_s); end
      wait_pulse(20, n);
      vectors++; if (n !== 10) begin miscompares++; $display("FAIL first_spacing: got %0d want 32", n + 22); end
      vectors++; if (remaining_s !== 16'd0) begin miscompares++; $display("FAIL first_rem0: got %0d want 0", remaining_s); end
   endtask

   task automatic test_controller_seq();
      int n;
      seconds_to_count = 16'd17;
      wait_pulse(300, n);
      vectors++; if (n !== 172) begin miscompares++; $display("FAIL seq_17: spacing %0d want 172", n); end
      seconds_to_count = 16'd3;
      wait_pulse(100, n);
      vectors++; if (n !== 32) begin miscompares++; $display("FAIL seq_3: spacing %0d want 32", n); end
      seconds_to_count = 16'd1;
      wait_pulse(100, n);
      vectors++; if (n !== 12) begin miscompares++; $display("FAIL seq_1: spacing %0d want 12", n); end
   endtask

   task automatic test_zero_clamp();
      int n;
      seconds_to_count = 16'd0;
      tick(1);
      vectors++; if (busy !== 1'b1 || finished !== 1'b0) begin miscompares++; $display("FAIL zero_load: busy=%b finished=%b want 1/0", busy, finished); end
      tick(1);
      vectors++; if (remaining_s !== 16'd1) begin miscompares++; $display("FAIL zero_clamp: got %0d want 1", remaining_s); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL zero_run_busy: busy=%b want 1", busy); end
      wait_pulse(100, n);
      vectors++; if (n !== 10) begin miscompares++; $display("FAIL zero_spacing: got %0d want 12", n + 2); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_req_busy: busy=%b want 0", busy); end
   endtask

   task automatic test_enable_drop();
      int n;
      seconds_to_count = 16'd8;
      tick(2);
      tick(30);
      vectors++; if (remaining_s !== 16'd5) begin miscompares++; $display("FAIL drop_rem5: got %0d want 5", remaining_s); end
      tick(4);
      enable = 1'b0;
      tick(1);
      vectors++; if (finished !== 1'b0 || busy !== 1'b0 || remaining_s !== 16'd0) begin
         miscompares++; $display("FAIL drop_idle: finished=%b busy=%b rem=%0d want 0/0/0", finished, busy, remaining_s);
      end
      tick(6);
      vectors++; if (finished !== 1'b0 || busy !== 1'b0 || remaining_s !== 16'd0) begin
         miscompares++; $display("FAIL drop_hold: finished=%b busy=%b rem=%0d want 0/0/0", finished, busy, remaining_s);
      end
      enable = 1'b1;
      tick(1);
      vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL drop_restart_pulse: finished=%b want 1", finished); end
      tick(2);
      vectors++; if (remaining_s !== 16'd8) begin miscompares++; $display("FAIL drop_full_reload: got %0d want 8", remaining_s); end
      wait_pulse(200, n);
      vectors++; if (n !== 80) begin miscompares++; $display("FAIL drop_restart_spacing: got %0d want 82", n + 2); end
   endtask

   task automatic test_reset_mid_run();
      int n;
      seconds_to_count = 16'd3;
      tick(7);
      #2 reset = 1'b0;
      #1;
      vectors++; if (finished !== 1'b0 || busy !== 1'b0 || remaining_s !== 16'd0) begin
         miscompares++; $display("FAIL rst_async: finished=%b busy=%b rem=%0d want 0/0/0", finished, busy, remaining_s);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1);
         vectors++; if (finished !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL rst_hold%0d: finished=%b busy=%b want 0/0", i, finished, busy);
         end
      end
      reset = 1'b1;
      tick(1);
      vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL rst_restart_pulse: finished=%b want 1", finished); end
      wait_pulse(100, n);
      vectors++; if (n !== 32) begin miscompares++; $display("FAIL rst_restart_spacing: got %0d want 32", n); end
   endtask

`ifdef PHASE_TIMER_PAUSE_EN
   task automatic test_pause();
      int n;
      seconds_to_count = 16'd2;
      tick(2);
      tick(9);
      pause = 1'b1;
      tick(6);
      vectors++; if (remaining_s !== 16'd2) begin miscompares++; $display("FAIL pause_frozen: got %0d want 2", remaining_s); end
      pause = 1'b0;
      wait_pulse(100, n);
      vectors++; if (n !== 11) begin miscompares++; $display("FAIL pause_spacing: got %0d want 28", n + 17); end
   endtask
`endif

   initial begin
      test_reset();
      test_first_phase();
      test_controller_seq();
      test_zero_clamp();
      test_enable_drop();
      test_reset_mid_run();
`ifdef PHASE_TIMER_PAUSE_EN
      test_pause();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/phase_timer.md
Name: phase_timer

Overview:
- Seconds-based phase timer that closes the timing handshake with the traffic-light controller.
- The controller drives the requested phase duration on `seconds_to_count` and advances one state per `finished` pulse.
- This block counts that duration in whole seconds from the 10 kHz system clock, then pulses `finished`.
- It then samples the controller's next duration and repeats.

Parameters:
- CLK_HZ, 10000: clk cycles per second; must be ≥ 2.
- CNT_W, 16: width of the seconds count and `remaining_s`.
- PRE_W, $clog2(CLK_HZ): prescaler width; derived, not overridden.

Ports:
- clk  in  1  system clock (10 kHz).
- reset  in  1  asynchronous reset, active-low; 0 = reset.
- enable  in  1  system enable; 0 forces IDLE.
- seconds_to_count  in  CNT_W  requested phase duration in seconds; driven by the controller.
- finished  out  1  one-cycle pulse: phase elapsed, controller may advance.
- busy  out  1  high in LOAD and RUN.
- remaining_s  out  CNT_W  seconds left in the current phase, including the partial second (status/debug).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, finished=0, busy=0, remaining_s=0, prescaler=0.
- Outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, REQ, LOAD, RUN.
- IDLE:
  - All outputs 0.
  - enable=1 at an edge → REQ.
- REQ:
  - finished=1 for exactly this one cycle.
  - Next edge → LOAD.
  - enable=0 → IDLE; the pulse still completes this cycle.
- LOAD:
  - finished=0.
  - Samples seconds_to_count at the LOAD→RUN edge. The controller updates its duration on the same edge that consumes the pulse, so the value is stable during LOAD.
  - remaining_s ← sampled value; a value of 0 is clamped to 1.
  - prescaler ← 0; → RUN.
- RUN:
  - prescaler increments each cycle.
  - At prescaler = CLK_HZ-1: prescaler wraps to 0 and remaining_s decrements.
  - If remaining_s = 1 at that wrap: remaining_s → 0, next state REQ.
- Timing: for a sampled value N ≥ 1, the spacing between consecutive finished rising edges is exactly N·CLK_HZ + 2 cycles (REQ + LOAD + N·CLK_HZ RUN cycles). N=0 behaves as N=1.
- First pulse after reset release with enable=1: finished is high in the 2nd cycle after the first edge that sees enable=1.
- enable=0 in any state: at the next edge go to IDLE, clear the prescaler and remaining_s, finished=0.
- enable re-asserted: restarts from REQ; there is no resume.
- seconds_to_count changes during RUN are ignored; only the LOAD sample matters.
- Reset mid-RUN: immediate return to reset values; no spurious finished pulse.
- Max duration: N = 2^CNT_W-1. There is no overflow path, because remaining_s only decrements.

Optional Feature:
- Macro: PHASE_TIMER_PAUSE_EN.
- When defined:
  - Adds input port `pause` (1 bit).
  - While pause=1 in RUN, the prescaler and remaining_s hold.
  - pause in IDLE/REQ/LOAD has no effect.
  - Pulse spacing grows by exactly the number of paused RUN cycles.
- When undefined: the port is absent and behaviour is as above.

Decomposition:
- Package phase_timer_pkg: state encoding constants (IDLE=2'd0, REQ=2'd1, LOAD=2'd2, RUN=2'd3), default CLK_HZ=10000, default CNT_W=16.
- Sub-module tick_prescaler:
  - Inputs: clk, reset, clear, run.
  - Output: `sec_tick`, a one-cycle pulse at prescaler wrap.
  - The parent uses sec_tick to decrement remaining_s.

Test Plan (CLK_HZ=10 for simulation unless stated):
1. Reset released, enable=1, seconds_to_count=3 → finished pulses for 1 cycle at cycle 2; next pulse exactly 32 cycles later; remaining_s reads 3,2,1 in ten-cycle steps.
2. Controller model changes seconds_to_count 17→3→1 on each pulse → pulse spacings of 172, 32, 12 cycles.
3. seconds_to_count=0 → spacing 12 cycles (clamped to 1); busy high in LOAD/RUN only.
4. enable dropped mid-RUN at remaining_s=5, re-raised 7 cycles later → IDLE with outputs 0; restart gives a pulse 2 cycles after re-enable and a full new duration.
5. reset pulled low mid-RUN for 3 cycles → outputs go to 0 immediately with no finished pulse; sequence restarts as in test 1.
6. With PHASE_TIMER_PAUSE_EN, N=2, pause high for 6 RUN cycles → spacing 28 cycles and remaining_s frozen while paused.
